// File: rtl/bfm_sink_stream_chk.sv
// AXI4-Stream image sink/checker: throttles tready, checks SOF/EOL geometry against the
// programmed frame size and an incrementing data pattern, and counts good/bad frames and errors.
module bfm_sink_stream_chk #(
    parameter int unsigned DATA_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       IMG_WIDTH,
    input  logic [15:0]       IMG_HEIGHT,
    input  logic [1:0]        READY_MODE,
    input  logic              DATA_CHK_EN,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       frame_bad_cnt,
    output logic [15:0]       err_sof_cnt,
    output logic [15:0]       err_eol_cnt,
    output logic [15:0]       err_data_cnt,
    output logic              err_flag
);

    typedef enum logic [0:0] {StWaitSof, StInFrame} state_e;

    localparam logic [1:0] ModeAlways = 2'd0;
    localparam logic [1:0] ModeLfsr   = 2'd1;
    localparam logic [1:0] ModeToggle = 2'd2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              tready_q, tready_d;
    logic [15:0]       col_q, col_d;
    logic [15:0]       row_q, row_d;
    logic              frame_err_q, frame_err_d;
    logic [DATA_W-1:0] ref_q, ref_d;
    logic              ref_vld_q, ref_vld_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       frame_bad_q, frame_bad_d;
    logic [15:0]       sof_cnt_q, sof_cnt_d;
    logic [15:0]       eol_cnt_q, eol_cnt_d;
    logic [15:0]       data_cnt_q, data_cnt_d;
    logic              err_flag_q, err_flag_d;

    logic [15:0]       w_last, h_last;
    logic              xfer, start, in_frame_beat;
    logic              sof_err, eol_err, data_err, beat_err, base_err;
    logic [15:0]       cur_col, cur_row;
    logic              line_end, last_row;
    logic              frame_good, frame_bad;
    logic [DATA_W-1:0] data_exp;

    // A zero dimension behaves as one pixel/line.
    assign w_last = (IMG_WIDTH == 16'd0) ? 16'd0 : IMG_WIDTH - 16'd1;
    assign h_last = (IMG_HEIGHT == 16'd0) ? 16'd0 : IMG_HEIGHT - 16'd1;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        case (READY_MODE)
            ModeAlways: tready_d = 1'b1;
            ModeLfsr:   tready_d = lfsr_q[0];
            ModeToggle: tready_d = ~tready_q;
            default:    tready_d = 1'b0;
        endcase
    end

    assign xfer     = s_axis_tvalid & tready_q;
    assign data_exp = ref_q + DATA_W'(1);
    assign data_err = xfer & DATA_CHK_EN & ref_vld_q & (s_axis_tdata != data_exp);

    assign start         = xfer & s_axis_tuser;
    assign in_frame_beat = xfer & (s_axis_tuser | (state_q == StInFrame));
    assign sof_err       = xfer & (s_axis_tuser ? (state_q == StInFrame)
                                                : (state_q == StWaitSof));

    // An SOF beat always restarts geometry at pixel (0,0) with a clean frame history.
    assign cur_col  = start ? 16'd0 : col_q;
    assign cur_row  = start ? 16'd0 : row_q;
    assign base_err = start ? 1'b0 : frame_err_q;
    assign line_end = (cur_col == w_last);
    assign last_row = (cur_row == h_last);
    assign eol_err  = in_frame_beat & (s_axis_tlast != line_end);
    assign beat_err = base_err | eol_err | data_err;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_err_d = frame_err_q;
        frame_good  = 1'b0;
        frame_bad   = 1'b0;
        if (in_frame_beat) begin
            frame_err_d = beat_err;
            state_d     = StInFrame;
            if (line_end) begin
                col_d = 16'd0;
                if (last_row) begin
                    row_d      = 16'd0;
                    state_d    = StWaitSof;
                    frame_good = ~beat_err;
                    frame_bad  = beat_err;
                end else begin
                    row_d = cur_row + 16'd1;
                end
            end else begin
                col_d = cur_col + 16'd1;
                row_d = cur_row;
            end
        end
    end

    // The reference tracks every accepted beat even while checking is disabled.
    always_comb begin
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        if (xfer) begin
            ref_d     = s_axis_tdata;
            ref_vld_d = 1'b1;
        end
    end

    always_comb begin
        frame_cnt_d = sat_inc(frame_cnt_q, frame_good);
        frame_bad_d = sat_inc(frame_bad_q, frame_bad);
        sof_cnt_d   = sat_inc(sof_cnt_q, sof_err);
        eol_cnt_d   = sat_inc(eol_cnt_q, eol_err);
        data_cnt_d  = sat_inc(data_cnt_q, data_err);
        err_flag_d  = err_flag_q | sof_err | eol_err | data_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StWaitSof;
            lfsr_q      <= LFSR_SEED;
            tready_q    <= 1'b0;
            col_q       <= 16'd0;
            row_q       <= 16'd0;
            frame_err_q <= 1'b0;
            ref_q       <= '0;
            ref_vld_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
            frame_bad_q <= 16'd0;
            sof_cnt_q   <= 16'd0;
            eol_cnt_q   <= 16'd0;
            data_cnt_q  <= 16'd0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tready_q    <= tready_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_err_q <= frame_err_d;
            ref_q       <= ref_d;
            ref_vld_q   <= ref_vld_d;
            frame_cnt_q <= frame_cnt_d;
            frame_bad_q <= frame_bad_d;
            sof_cnt_q   <= sof_cnt_d;
            eol_cnt_q   <= eol_cnt_d;
            data_cnt_q  <= data_cnt_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign frame_cnt     = frame_cnt_q;
    assign frame_bad_cnt = frame_bad_q;
    assign err_sof_cnt   = sof_cnt_q;
    assign err_eol_cnt   = eol_cnt_q;
    assign err_data_cnt  = data_cnt_q;
    assign err_flag      = err_flag_q;

endmodule

// File: tb/tb_bfm_sink_stream_chk.sv
// Directed bench for bfm_sink_stream_chk: table of stream scenarios with expected counters,
// plus hand sequences for tready patterns, mid-frame reset and hold-low mode.
module tb_bfm_sink_stream_chk;

    localparam int KClean   = 0;
    localparam int KEol     = 1;
    localparam int KNoSof   = 2;
    localparam int KRestart = 3;
    localparam int KData    = 4;
    localparam int Big      = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] img_width = 16'd4;
    logic [15:0] img_height = 16'd3;
    logic [1:0]  ready_mode = 2'd0;
    logic        data_chk_en = 1'b1;
    logic        tvalid = 1'b0;
    logic [15:0] tdata = 16'd0;
    logic        tuser = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic [15:0] frame_cnt, frame_bad_cnt, err_sof_cnt, err_eol_cnt, err_data_cnt;
    logic        err_flag;

    int          total = 0;
    int          bad = 0;
    logic [15:0] dval;

    typedef struct {
        int w, h, mode, chk, kind, nfr;
        int e_frame, e_bad, e_sof, e_eol, e_data, e_flag;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    bfm_sink_stream_chk #(
        .DATA_W   (16),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IMG_WIDTH    (img_width),
        .IMG_HEIGHT   (img_height),
        .READY_MODE   (ready_mode),
        .DATA_CHK_EN  (data_chk_en),
        .s_axis_tvalid(tvalid),
        .s_axis_tdata (tdata),
        .s_axis_tuser (tuser),
        .s_axis_tlast (tlast),
        .s_axis_tready(tready),
        .frame_cnt    (frame_cnt),
        .frame_bad_cnt(frame_bad_cnt),
        .err_sof_cnt  (err_sof_cnt),
        .err_eol_cnt  (err_eol_cnt),
        .err_data_cnt (err_data_cnt),
        .err_flag     (err_flag)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int f, input int b, input int s,
                             input int e, input int d, input int fl);
        check({tag, ".frame_cnt"}, int'(frame_cnt), f);
        check({tag, ".frame_bad_cnt"}, int'(frame_bad_cnt), b);
        check({tag, ".err_sof_cnt"}, int'(err_sof_cnt), s);
        check({tag, ".err_eol_cnt"}, int'(err_eol_cnt), e);
        check({tag, ".err_data_cnt"}, int'(err_data_cnt), d);
        check({tag, ".err_flag"}, int'(err_flag), fl);
    endtask

    // Leaves the bench at the negedge right after the reset edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; holds the beat until it is accepted, returns at a negedge.
    task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
        int   n;
        logic ok;
        n      = 0;
        tvalid = 1'b1;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        while (1) begin
            ok = tready;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("beat_accept_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int eol_bug, input int max_beats);
        int b;
        b = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (b >= max_beats) return;
                send_beat(dval, (r == 0) && (c == 0),
                          (eol_bug != 0 && r == 0) ? (c == 2) : (c == w - 1));
                dval = dval + 16'd1;
                b++;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m_lfsr;
        logic        m_rdy;
        logic [15:0] dvals[5];
        int          we, he, highs;

        // w h mode chk kind nfr | frame bad sof eol data flag
        vecs[0] = '{4, 3, 0, 1, KClean,   3, 3, 0, 0, 0, 0, 0};
        vecs[1] = '{4, 3, 1, 1, KClean,   3, 3, 0, 0, 0, 0, 0};
        vecs[2] = '{4, 3, 2, 1, KClean,   3, 3, 0, 0, 0, 0, 0};
        vecs[3] = '{4, 2, 0, 1, KEol,     1, 0, 1, 0, 2, 0, 1};
        vecs[4] = '{4, 3, 1, 1, KNoSof,   1, 1, 0, 5, 0, 0, 1};
        vecs[5] = '{4, 3, 0, 1, KRestart, 1, 1, 0, 1, 0, 0, 1};
        vecs[6] = '{5, 1, 0, 1, KData,    1, 0, 1, 0, 0, 1, 1};
        vecs[7] = '{5, 1, 2, 0, KData,    1, 1, 0, 0, 0, 0, 0};
        vecs[8] = '{0, 0, 0, 1, KClean,   3, 3, 0, 0, 0, 0, 0};
        dvals   = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd8};

        for (int i = 0; i < 9; i++) begin
            ready_mode  = 2'(vecs[i].mode);
            data_chk_en = (vecs[i].chk != 0);
            img_width   = 16'(vecs[i].w);
            img_height  = 16'(vecs[i].h);
            do_reset();
            dval = 16'd0;
            we   = (vecs[i].w == 0) ? 1 : vecs[i].w;
            he   = (vecs[i].h == 0) ? 1 : vecs[i].h;
            case (vecs[i].kind)
                KClean:   for (int f = 0; f < vecs[i].nfr; f++) send_frame(we, he, 0, Big);
                KEol:     send_frame(we, he, 1, Big);
                KNoSof: begin
                    for (int k = 0; k < 5; k++) begin
                        send_beat(dval, 1'b0, 1'b0);
                        dval = dval + 16'd1;
                    end
                    send_frame(we, he, 0, Big);
                end
                KRestart: begin
                    send_frame(we, he, 0, we + 2);
                    send_frame(we, he, 0, Big);
                end
                default: begin
                    for (int k = 0; k < 5; k++) send_beat(dvals[k], k == 0, k == 4);
                end
            endcase
            repeat (3) @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_frame, vecs[i].e_bad, vecs[i].e_sof,
                      vecs[i].e_eol, vecs[i].e_data, vecs[i].e_flag);
        end

        // tready sequence per mode, against a model started from the seed.
        for (int mode = 0; mode < 3; mode++) begin
            ready_mode = 2'(mode);
            do_reset();
            m_lfsr = 16'hACE1;
            m_rdy  = 1'b0;
            for (int c = 0; c < 40; c++) begin
                check($sformatf("tready.mode%0d.cyc%0d", mode, c), int'(tready), int'(m_rdy));
                case (mode)
                    0:       m_rdy = 1'b1;
                    1:       m_rdy = m_lfsr[0];
                    default: m_rdy = ~m_rdy;
                endcase
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
                @(negedge clk);
            end
        end

        // Reset in the middle of row 1 discards the partial frame and all counts.
        ready_mode  = 2'd0;
        data_chk_en = 1'b1;
        img_width   = 16'd4;
        img_height  = 16'd3;
        do_reset();
        dval = 16'd0;
        for (int k = 0; k < 2; k++) begin
            send_beat(dval, 1'b0, 1'b0);
            dval = dval + 16'd1;
        end
        send_frame(4, 3, 0, 6);
        check("pre_reset.err_sof_cnt", int'(err_sof_cnt), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all("mid_reset", 0, 0, 0, 0, 0, 0);
        check("mid_reset.tready", int'(tready), 0);
        send_frame(4, 3, 0, Big);
        repeat (2) @(negedge clk);
        check_all("post_reset", 1, 0, 0, 0, 0, 0);

        // Hold-low mode: nothing is accepted, so counters stay frozen.
        ready_mode = 2'd3;
        repeat (2) @(negedge clk);
        highs  = 0;
        tvalid = 1'b1;
        tuser  = 1'b1;
        tlast  = 1'b1;
        tdata  = 16'h1234;
        for (int c = 0; c < 12; c++) begin
            if (tready) highs++;
            @(negedge clk);
        end
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        check("hold_low.tready_high_cycles", highs, 0);
        check_all("hold_low", 1, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
